// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: accepts an operation in IDLE, shifts up to STEP bits per cycle,
// then pulses done for one cycle with the result and the last bit shifted out.
module shift_rotate_unit #(
  parameter  int DATA_WIDTH = 32,
  parameter  int STEP       = 1,
  localparam int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [AMT_WIDTH-1:0]  amount_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_out_o
);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  localparam logic [AMT_WIDTH:0] STEP_W = (AMT_WIDTH+1)'(STEP);
  localparam logic [AMT_WIDTH:0] W_EXT  = (AMT_WIDTH+1)'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [AMT_WIDTH-1:0]  rem_q, rem_d;
  logic                  carry_q, carry_d;
  logic                  busy_q, done_q;

  logic [AMT_WIDTH-1:0]  step_amt, step_m1;
  logic [AMT_WIDTH:0]    step_inv;
  logic [DATA_WIDTH-1:0] shr_v, shra_v, shl_v, ror_v, rol_v;

  // Per-cycle step is min(STEP, remaining); step_inv = W - step drives the wrap half of rotates.
  always_comb begin
    step_amt = rem_q;
    if ({1'b0, rem_q} >= STEP_W) step_amt = STEP_W[AMT_WIDTH-1:0];
    step_m1  = step_amt - AMT_WIDTH'(1);
    step_inv = W_EXT - {1'b0, step_amt};
    shr_v    = result_q >> step_amt;
    shra_v   = DATA_WIDTH'($signed(result_q) >>> step_amt);
    shl_v    = result_q << step_amt;
    ror_v    = (result_q >> step_amt) | (result_q << step_inv);
    rol_v    = (result_q << step_amt) | (result_q >> step_inv);
  end

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    rem_d    = rem_q - step_amt;
    case (op_q)
      OP_SHR:  begin result_d = shr_v;  carry_d = result_q[step_m1]; end
      OP_SHRA: begin result_d = shra_v; carry_d = result_q[step_m1]; end
      OP_SHL:  begin result_d = shl_v;  carry_d = result_q[step_inv[AMT_WIDTH-1:0]]; end
      OP_ROR:  begin result_d = ror_v;  carry_d = ror_v[DATA_WIDTH-1]; end
      OP_ROL:  begin result_d = rol_v;  carry_d = rol_v[0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            result_q <= operand_i;
            rem_q    <= amount_i;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0 | 1'b1;
            if (amount_i != '0 && op_i <= OP_ROL) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          rem_q    <= rem_d;
          if (rem_d == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench: one STEP=1 and one STEP=4 instance share stimulus; results must agree,
// latencies differ by ceil(N/STEP).
module tb_shift_rotate_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand = '0;
  logic [4:0]  amount = '0;

  logic        busy1, done1, carry1, busy4, done4, carry4;
  logic [31:0] result1, result4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_rotate_unit #(.DATA_WIDTH(32), .STEP(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .operand_i(operand), .amount_i(amount),
    .busy_o(busy1), .done_o(done1), .result_o(result1), .carry_out_o(carry1));

  shift_rotate_unit #(.DATA_WIDTH(32), .STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .operand_i(operand), .amount_i(amount),
    .busy_o(busy4), .done_o(done4), .result_o(result4), .carry_out_o(carry4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, follow both instances to done, check result, carry and latency.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] opnd,
                        input logic [4:0] amt, input logic [31:0] exp_res, input logic exp_c,
                        input int exp_l1, input int exp_l4, input bit inject);
    int cyc = 0;
    int l1 = -1, l4 = -1, n4 = 0;
    bit busy_ok = 1'b1;
    logic [31:0] r1 = '0, r4 = '0;
    logic c1 = 1'b0, c4 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand = opnd; amount = amt;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_acc"}, 32'(busy1), 32'd1);
    while (l1 < 0 && cyc < 100) begin
      if (done1) begin l1 = cyc; r1 = result1; c1 = carry1; end
      if (done4) begin
        if (l4 < 0) begin l4 = cyc; r4 = result4; c4 = carry4; end
        n4++;
      end
      if (!busy1) busy_ok = 1'b0;
      if (inject && cyc == 2) begin start = 1'b1; op = 3'b100; operand = 32'h1; amount = 5'd1; end
      if (inject && cyc == 3) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".lat1"}, 32'(l1), 32'(exp_l1));
    chk({tag, ".lat4"}, 32'(l4), 32'(exp_l4));
    chk({tag, ".res1"}, r1, exp_res);
    chk({tag, ".res4"}, r4, exp_res);
    chk({tag, ".c1"}, 32'(c1), 32'(exp_c));
    chk({tag, ".c4"}, 32'(c4), 32'(exp_c));
    chk({tag, ".busy_thru"}, 32'(busy_ok), 32'd1);
    chk({tag, ".done1_once"}, 32'(done1), 32'd0);
    chk({tag, ".done4_cnt"}, 32'(n4), 32'd1);
    chk({tag, ".busy_after"}, 32'(busy1), 32'd0);
    chk({tag, ".res_hold"}, result1, exp_res);
  endtask

  initial begin
    int nd;
    #12;
    chk("rst.busy", 32'(busy1), 32'd0);
    chk("rst.done", 32'(done1), 32'd0);
    chk("rst.result", result1, 32'd0);
    chk("rst.carry", 32'(carry4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("ror1",     3'b011, 32'h0000007F, 5'd1,  32'h8000003F, 1'b1, 1,  1, 1'b0);
    run_op("shra4",    3'b001, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 4,  1, 1'b0);
    run_op("shl0",     3'b010, 32'h00000012, 5'd0,  32'h00000012, 1'b0, 0,  0, 1'b0);
    run_op("pass7",    3'b111, 32'h12345678, 5'd5,  32'h12345678, 1'b0, 0,  0, 1'b0);
    run_op("rol8",     3'b100, 32'h12345678, 5'd8,  32'h34567812, 1'b0, 8,  2, 1'b0);
    run_op("shr5",     3'b000, 32'h000000F0, 5'd5,  32'h00000007, 1'b1, 5,  2, 1'b0);
    run_op("shl1",     3'b010, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1,  1, 1'b0);
    run_op("rol1",     3'b100, 32'h80000000, 5'd1,  32'h00000001, 1'b1, 1,  1, 1'b0);
    run_op("shr31",    3'b000, 32'hC0000000, 5'd31, 32'h00000001, 1'b1, 31, 8, 1'b0);
    run_op("shra31",   3'b001, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 31, 8, 1'b0);
    run_op("shl31",    3'b010, 32'h00000003, 5'd31, 32'h80000000, 1'b1, 31, 8, 1'b0);
    run_op("ror4",     3'b011, 32'h12345678, 5'd4,  32'h81234567, 1'b1, 4,  1, 1'b0);
    run_op("ignore",   3'b000, 32'hFFFF0000, 5'd16, 32'h0000FFFF, 1'b0, 16, 4, 1'b1);

    // Asynchronous clear in the middle of a shift, between clock edges.
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; operand = 32'hFFFF0000; amount = 5'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("clr.pre_busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    chk("clr.busy", 32'(busy1), 32'd0);
    chk("clr.done", 32'(done1), 32'd0);
    chk("clr.result", result1, 32'd0);
    chk("clr.carry", 32'(carry1), 32'd0);
    chk("clr.busy4", 32'(busy4), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done1 || done4) nd++;
    end
    chk("clr.no_done", 32'(nd), 32'd0);
    run_op("post_clr", 3'b011, 32'h00000001, 5'd1, 32'h80000000, 1'b1, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
